// File: rtl/br_pkg.sv
// Shared definitions for the ID-stage branch redirect controller: condition
// codes, controller states and the branch target arithmetic.
package br_pkg;

    localparam logic [2:0] BR_LTZ = 3'd0;
    localparam logic [2:0] BR_GEZ = 3'd1;
    localparam logic [2:0] BR_LEZ = 3'd2;
    localparam logic [2:0] BR_GTZ = 3'd3;
    localparam logic [2:0] BR_EQ  = 3'd4;
    localparam logic [2:0] BR_NE  = 3'd5;
    localparam logic [2:0] BR_NEZ = 3'd6;
    localparam logic [2:0] BR_RSV = 3'd7;

    typedef logic [1:0] br_state_t;

    localparam br_state_t IDLE      = 2'd0;
    localparam br_state_t WAIT_OPND = 2'd1;
    localparam br_state_t REDIRECT  = 2'd2;

    // Widest PC the target helper supports; callers truncate to their width.
    localparam int BR_MAX_W = 64;

    // The reserved code never takes, whatever the comparator reports.
    function automatic logic br_cond_valid(input logic [2:0] sel);
        case (sel)
            BR_LTZ, BR_GEZ, BR_LEZ, BR_GTZ,
            BR_EQ, BR_NE, BR_NEZ: return 1'b1;
            BR_RSV:               return 1'b0;
            default:              return 1'b0;
        endcase
    endfunction

    // Target = PC of the branch + 4 + word offset; wraps modulo the PC width.
    function automatic logic [BR_MAX_W-1:0] br_target(
        input logic [BR_MAX_W-1:0] pc,
        input logic [15:0]         imm
    );
        logic [BR_MAX_W-1:0] byte_off;
        byte_off = {{(BR_MAX_W-18){imm[15]}}, imm, 2'b00};
        return pc + BR_MAX_W'(4) + byte_off;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// ID-stage, comparator and fetch-redirect signals of the branch controller.
// master is the controller side, slave the pipeline side.
interface branch_redirect_ctrl_if #(
    parameter int ADDR_W = 32
) ();

    logic              id_valid;
    logic              id_is_branch;
    logic [2:0]        id_cmp_sel;
    logic [ADDR_W-1:0] id_pc;
    logic [15:0]       id_imm;
    logic              opnd_hazard;
    logic [2:0]        cmp_sel;
    logic              cmp_zero;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              if_ready;
    logic              ds_branch_err;

    modport master (
        input  id_valid, id_is_branch, id_cmp_sel, id_pc, id_imm,
        input  opnd_hazard, cmp_zero, if_ready,
        output cmp_sel, stall, redirect_valid, redirect_pc, ds_branch_err
    );

    modport slave (
        output id_valid, id_is_branch, id_cmp_sel, id_pc, id_imm,
        output opnd_hazard, cmp_zero, if_ready,
        input  cmp_sel, stall, redirect_valid, redirect_pc, ds_branch_err
    );

endinterface

// File: rtl/br_target_calc.sv
// Branch target adder: sign-extend the word offset, scale to bytes, add to PC+4.
module br_target_calc
    import br_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [15:0]       imm,
    output logic [ADDR_W-1:0] target
);

    assign target = ADDR_W'(br_target(BR_MAX_W'(pc), imm));

endmodule

// File: rtl/branch_redirect_ctrl.sv
// ID-stage branch controller: operand-hazard stall, branch resolve, held fetch
// redirect with valid/ready handshake, delay-slot policing and statistics.
module branch_redirect_ctrl
    import br_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_redirect_ctrl_if.master bus,
    output logic [CNT_W-1:0]       br_total,
    output logic [CNT_W-1:0]       br_taken
);

    br_state_t         state;
    br_state_t         state_nxt;
    logic              ds_pending;
    logic              seen;
    logic              taken;
    logic              resolve;
    logic              stall_raw;
    logic              ds_err_nxt;
    logic [ADDR_W-1:0] target;

    assign bus.cmp_sel = bus.id_cmp_sel;
    assign seen        = bus.id_valid && bus.id_is_branch;
    assign taken       = br_cond_valid(bus.id_cmp_sel) && !bus.cmp_zero;
    assign bus.stall   = rst_n && stall_raw;

    br_target_calc #(
        .ADDR_W (ADDR_W)
    ) u_target (
        .pc     (bus.id_pc),
        .imm    (bus.id_imm),
        .target (target)
    );

    always_comb begin
        // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
        state_nxt  = state;
        stall_raw  = 1'b0;
        resolve    = 1'b0;
        ds_err_nxt = seen && ds_pending;

        case (state)
            IDLE: begin
                // A branch sitting in the delay slot is flagged, never resolved.
                if (seen && !ds_pending) begin
                    if (bus.opnd_hazard) begin
                        stall_raw = 1'b1;
                        state_nxt = WAIT_OPND;
                    end else begin
                        resolve = 1'b1;
                    end
                end
            end
            WAIT_OPND: begin
                if (bus.opnd_hazard) begin
                    stall_raw = 1'b1;
                end else begin
                    resolve = 1'b1;
                end
            end
            REDIRECT: begin
                // Only the delay-slot instruction may leave ID before fetch accepts.
                stall_raw = bus.id_valid && !ds_pending;
                if (bus.if_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (resolve) begin
            state_nxt = taken ? REDIRECT : IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            ds_pending        <= 1'b0;
            bus.ds_branch_err <= 1'b0;
        end else begin
            state             <= state_nxt;
            bus.ds_branch_err <= ds_err_nxt;
            if (resolve) begin
                ds_pending <= 1'b1;
            end else if (bus.id_valid && !stall_raw) begin
                ds_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
        end else if (resolve && taken) begin
            bus.redirect_valid <= 1'b1;
            bus.redirect_pc    <= target;
        end else if (state == REDIRECT && bus.if_ready) begin
            bus.redirect_valid <= 1'b0;
        end
    end

    // Statistics saturate at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_total <= '0;
            br_taken <= '0;
        end else if (resolve) begin
            if (br_total != '1) begin
                br_total <= br_total + CNT_W'(1);
            end
            if (taken && br_taken != '1) begin
                br_taken <= br_taken + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios plus
// randomized branch episodes against an episode-level reference model.
module tb_branch_redirect_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_is_branch;
    logic [2:0]  id_cmp_sel;
    logic [31:0] id_pc;
    logic [15:0] id_imm;
    logic        opnd_hazard;
    logic        cmp_zero;
    logic        if_ready;

    logic [15:0] br_total;
    logic [15:0] br_taken;
    logic [1:0]  s_total;
    logic [1:0]  s_taken;

    int          checks;
    int          failures;
    int unsigned m_total;
    int unsigned m_taken;

    branch_redirect_ctrl_if #(.ADDR_W(32)) bus ();
    branch_redirect_ctrl_if #(.ADDR_W(32)) bus_s ();

    assign bus.id_valid       = id_valid;
    assign bus.id_is_branch   = id_is_branch;
    assign bus.id_cmp_sel     = id_cmp_sel;
    assign bus.id_pc          = id_pc;
    assign bus.id_imm         = id_imm;
    assign bus.opnd_hazard    = opnd_hazard;
    assign bus.cmp_zero       = cmp_zero;
    assign bus.if_ready       = if_ready;
    assign bus_s.id_valid     = id_valid;
    assign bus_s.id_is_branch = id_is_branch;
    assign bus_s.id_cmp_sel   = id_cmp_sel;
    assign bus_s.id_pc        = id_pc;
    assign bus_s.id_imm       = id_imm;
    assign bus_s.opnd_hazard  = opnd_hazard;
    assign bus_s.cmp_zero     = cmp_zero;
    assign bus_s.if_ready     = if_ready;

    branch_redirect_ctrl #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .br_total (br_total),
        .br_taken (br_taken)
    );

    // Narrow-counter copy sharing the same stimulus, for saturation.
    branch_redirect_ctrl #(.ADDR_W(32), .CNT_W(2)) dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_s),
        .br_total (s_total),
        .br_taken (s_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model helpers ----------------
    function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] imm);
        longint off;
        off = longint'($signed(imm)) * 4;
        return 32'(longint'(pc) + 4 + off);
    endfunction

    function automatic logic ref_taken(input logic [2:0] sel, input logic cz);
        return (sel != 3'd7) && !cz;
    endfunction

    function automatic logic [15:0] sat16(input int unsigned n);
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    function automatic logic [1:0] sat2(input int unsigned n);
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid     = 1'b0;
        id_is_branch = 1'b0;
        id_cmp_sel   = 3'd0;
        id_pc        = 32'h0;
        id_imm       = 16'h0;
        opnd_hazard  = 1'b0;
        cmp_zero     = 1'b1;
        if_ready     = 1'b0;
    endtask

    task automatic set_branch(input logic [2:0] sel, input logic cz, input logic [31:0] pc,
                              input logic [15:0] imm, input logic hz);
        id_valid     = 1'b1;
        id_is_branch = 1'b1;
        id_cmp_sel   = sel;
        cmp_zero     = cz;
        id_pc        = pc;
        id_imm       = imm;
        opnd_hazard  = hz;
    endtask

    task automatic set_plain(input logic rdy);
        set_idle();
        id_valid = 1'b1;
        if_ready = rdy;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_idle();
        tick();
        tick();
        rst_n   = 1'b1;
        m_total = 0;
        m_taken = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        set_branch(3'd4, 1'b0, 32'h0040_0000, 16'h0003, 1'b1);
        tick();
        @(negedge clk);
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rst_stall: got %b want 0", bus.stall); end
        checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL rst_rv: got %b want 0", bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 32'h0) begin failures++; $display("FAIL rst_rpc: got %h want 0", bus.redirect_pc); end
        checks++; if (bus.ds_branch_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", bus.ds_branch_err); end
        checks++; if (br_total !== 16'd0 || br_taken !== 16'd0) begin failures++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", br_total, br_taken); end
        checks++; if (bus.cmp_sel !== 3'd4) begin failures++; $display("FAIL rst_cmpsel: got %0d want 4", bus.cmp_sel); end
        tick();
        rst_n   = 1'b1;
        m_total = 0;
        m_taken = 0;
        set_idle();
        tick();
        @(negedge clk);
        checks++; if (bus.redirect_valid !== 1'b0 || bus.stall !== 1'b0) begin failures++; $display("FAIL rst_post: got rv=%b stall=%b want 0/0", bus.redirect_valid, bus.stall); end
    endtask

    task automatic test_taken_beq();
        do_reset();
        tick();
        set_branch(3'd4, 1'b0, 32'h0040_0000, 16'h0003, 1'b0);
        @(negedge clk);
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL beq_stall: got %b want 0", bus.stall); end
        checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL beq_rv_early: got %b want 0", bus.redirect_valid); end
        tick();
        set_plain(1'b0);
        @(negedge clk);
        checks++; if (bus.redirect_valid !== 1'b1) begin failures++; $display("FAIL beq_rv1: got %b want 1", bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 32'h0040_0010) begin failures++; $display("FAIL beq_pc1: got %h want 00400010", bus.redirect_pc); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL beq_ds_stall: got %b want 0", bus.stall); end
        tick();
        set_plain(1'b0);
        @(negedge clk);
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0040_0010) begin failures++; $display("FAIL beq_hold2: got %b/%h want 1/00400010", bus.redirect_valid, bus.redirect_pc); end
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL beq_hold_stall: got %b want 1", bus.stall); end
        tick();
        set_plain(1'b1);
        @(negedge clk);
        checks++; if (bus.redirect_valid !== 1'b1) begin failures++; $display("FAIL beq_hs_rv: got %b want 1", bus.redirect_valid); end
        tick();
        set_idle();
        @(negedge clk);
        checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL beq_drop: got %b want 0", bus.redirect_valid); end
        checks++; if (br_total !== 16'd1 || br_taken !== 16'd1) begin failures++; $display("FAIL beq_cnt: got %0d/%0d want 1/1", br_total, br_taken); end
    endtask

    task automatic test_not_taken_bne();
        do_reset();
        tick();
        set_branch(3'd5, 1'b1, 32'h0040_0100, 16'h0020, 1'b0);
        @(negedge clk);
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL bne_stall: got %b want 0", bus.stall); end
        tick();
        set_plain(1'b0);
        @(negedge clk);
        checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL bne_rv: got %b want 0", bus.redirect_valid); end
        tick();
        set_idle();
        @(negedge clk);
        checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL bne_rv2: got %b want 0", bus.redirect_valid); end
        checks++; if (br_total !== 16'd1 || br_taken !== 16'd0) begin failures++; $display("FAIL bne_cnt: got %0d/%0d want 1/0", br_total, br_taken); end
    endtask

    task automatic test_hazard();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            set_branch(3'd3, 1'b1, 32'h0000_1000, 16'h0010, 1'b1);
            @(negedge clk);
            checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL hz_stall%0d: got %b want 1", i, bus.stall); end
            checks++; if (bus.cmp_sel !== 3'd3) begin failures++; $display("FAIL hz_sel%0d: got %0d want 3", i, bus.cmp_sel); end
        end
        tick();
        set_branch(3'd3, 1'b0, 32'h0000_1000, 16'h0010, 1'b0);
        @(negedge clk);
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL hz_resolve_stall: got %b want 0", bus.stall); end
        checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL hz_rv3: got %b want 0", bus.redirect_valid); end
        tick();
        set_plain(1'b1);
        @(negedge clk);
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0000_1044) begin failures++; $display("FAIL hz_rv4: got %b/%h want 1/00001044", bus.redirect_valid, bus.redirect_pc); end
        tick();
        set_idle();
        @(negedge clk);
        checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL hz_drop: got %b want 0", bus.redirect_valid); end
        checks++; if (br_total !== 16'd1 || br_taken !== 16'd1) begin failures++; $display("FAIL hz_cnt: got %0d/%0d want 1/1", br_total, br_taken); end
    endtask

    task automatic test_offsets();
        logic [31:0] pcs  [2] = '{32'h0040_0008, 32'hFFFF_FFF8};
        logic [15:0] imms [2] = '{16'hFFFF, 16'h0002};
        logic [31:0] exps [2] = '{32'h0040_0008, 32'h0000_0004};
        for (int i = 0; i < 2; i++) begin
            do_reset();
            tick();
            set_branch(3'd6, 1'b0, pcs[i], imms[i], 1'b0);
            tick();
            set_plain(1'b1);
            @(negedge clk);
            checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== exps[i]) begin failures++; $display("FAIL off%0d_pc: got %b/%h want 1/%h", i, bus.redirect_valid, bus.redirect_pc, exps[i]); end
            tick();
            set_idle();
            @(negedge clk);
            checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL off%0d_drop: got %b want 0", i, bus.redirect_valid); end
        end
    endtask

    task automatic test_delay_slot_branch();
        logic seen_rv;
        do_reset();
        tick();
        set_branch(3'd4, 1'b0, 32'h0000_2000, 16'h0008, 1'b0);
        tick();
        set_branch(3'd4, 1'b0, 32'h0000_2004, 16'h0100, 1'b0);
        @(negedge clk);
        checks++; if (bus.stall !== 1'b0 || bus.ds_branch_err !== 1'b0) begin failures++; $display("FAIL ds_slot: got stall=%b err=%b want 0/0", bus.stall, bus.ds_branch_err); end
        tick();
        set_idle();
        @(negedge clk);
        checks++; if (bus.ds_branch_err !== 1'b1) begin failures++; $display("FAIL ds_err: got %b want 1", bus.ds_branch_err); end
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0000_2024) begin failures++; $display("FAIL ds_rpc: got %b/%h want 1/00002024", bus.redirect_valid, bus.redirect_pc); end
        tick();
        if_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.ds_branch_err !== 1'b0) begin failures++; $display("FAIL ds_err_pulse: got %b want 0", bus.ds_branch_err); end
        tick();
        set_idle();
        seen_rv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen_rv |= bus.redirect_valid;
            tick();
        end
        checks++; if (seen_rv !== 1'b0) begin failures++; $display("FAIL ds_one_redirect: got second redirect=%b want 0", seen_rv); end
        checks++; if (br_total !== 16'd1 || br_taken !== 16'd1) begin failures++; $display("FAIL ds_cnt: got %0d/%0d want 1/1", br_total, br_taken); end

        // Delay-slot branch arriving in the same cycle fetch accepts the redirect.
        do_reset();
        tick();
        set_branch(3'd0, 1'b0, 32'h0000_3000, 16'h0001, 1'b0);
        tick();
        set_branch(3'd1, 1'b0, 32'h0000_3004, 16'h0004, 1'b0);
        if_ready = 1'b1;
        tick();
        set_idle();
        @(negedge clk);
        checks++; if (bus.redirect_valid !== 1'b0 || bus.ds_branch_err !== 1'b1) begin failures++; $display("FAIL ds_hs: got rv=%b err=%b want 0/1", bus.redirect_valid, bus.ds_branch_err); end
        checks++; if (br_total !== 16'd1 || br_taken !== 16'd1) begin failures++; $display("FAIL ds_hs_cnt: got %0d/%0d want 1/1", br_total, br_taken); end
    endtask

    task automatic test_reset_abort();
        logic seen_rv;
        do_reset();
        tick();
        set_branch(3'd4, 1'b0, 32'h0000_4000, 16'h0005, 1'b0);
        tick();
        set_plain(1'b0);
        @(negedge clk);
        checks++; if (bus.redirect_valid !== 1'b1) begin failures++; $display("FAIL abort_pre_rv: got %b want 1", bus.redirect_valid); end
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL abort_rv: got %b want 0", bus.redirect_valid); end
        checks++; if (br_total !== 16'd0 || br_taken !== 16'd0) begin failures++; $display("FAIL abort_cnt: got %0d/%0d want 0/0", br_total, br_taken); end
        tick();
        rst_n = 1'b1;
        set_idle();
        tick();
        set_branch(3'd3, 1'b0, 32'h0000_5000, 16'h0002, 1'b1);
        @(negedge clk);
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL abort_wait_stall: got %b want 1", bus.stall); end
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL abort_wait_rst: got %b want 0", bus.stall); end
        tick();
        rst_n = 1'b1;
        set_idle();
        seen_rv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            seen_rv |= bus.redirect_valid;
        end
        checks++; if (seen_rv !== 1'b0) begin failures++; $display("FAIL abort_no_redirect: got %b want 0", seen_rv); end
        checks++; if (br_total !== 16'd0) begin failures++; $display("FAIL abort_total: got %0d want 0", br_total); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            set_branch(3'd4, 1'b0, 32'h0000_6000 + 32'(i * 64), 16'h0004, 1'b0);
            tick();
            set_plain(1'b1);
            tick();
            set_idle();
        end
        @(negedge clk);
        checks++; if (s_total !== 2'd3 || s_taken !== 2'd3) begin failures++; $display("FAIL sat_narrow: got %0d/%0d want 3/3", s_total, s_taken); end
        checks++; if (br_total !== 16'd5 || br_taken !== 16'd5) begin failures++; $display("FAIL sat_wide: got %0d/%0d want 5/5", br_total, br_taken); end
    endtask

    task automatic test_random();
        logic [2:0]  sel;
        logic        cz;
        logic        tk;
        logic        ds_br;
        logic [31:0] pc;
        logic [15:0] imm;
        logic [31:0] tgt;
        int          h;
        int          d;
        int          post;
        logic        hold;
        do_reset();
        for (int e = 0; e < 60; e++) begin
            sel   = 3'($urandom_range(0, 7));
            cz    = 1'($urandom_range(0, 1));
            pc    = $urandom() & 32'hFFFF_FFFC;
            imm   = 16'($urandom());
            h     = int'($urandom_range(0, 2));
            d     = int'($urandom_range(0, 3));
            ds_br = ($urandom_range(0, 4) == 0);
            tk    = ref_taken(sel, cz);
            tgt   = ref_target(pc, imm);

            for (int k = 0; k < h; k++) begin
                tick();
                set_branch(sel, 1'($urandom_range(0, 1)), pc, imm, 1'b1);
                @(negedge clk);
                checks++; if (bus.stall !== 1'b1 || bus.cmp_sel !== sel) begin failures++; $display("FAIL rnd%0d_hz: got stall=%b sel=%0d want 1/%0d", e, bus.stall, bus.cmp_sel, sel); end
            end
            tick();
            set_branch(sel, cz, pc, imm, 1'b0);
            @(negedge clk);
            checks++; if (bus.stall !== 1'b0 || bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL rnd%0d_res: got stall=%b rv=%b want 0/0", e, bus.stall, bus.redirect_valid); end
            m_total++;
            if (tk) m_taken++;

            tick();
            set_branch(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pc + 32'd4, 16'($urandom()), 1'($urandom_range(0, 1)));
            id_is_branch = ds_br;
            if_ready     = (d == 0);
            @(negedge clk);
            checks++; if (bus.stall !== 1'b0 || bus.redirect_valid !== tk) begin failures++; $display("FAIL rnd%0d_ds: got stall=%b rv=%b want 0/%b", e, bus.stall, bus.redirect_valid, tk); end
            if (tk) begin
                checks++; if (bus.redirect_pc !== tgt) begin failures++; $display("FAIL rnd%0d_pc: got %h want %h", e, bus.redirect_pc, tgt); end
            end

            post = tk ? d + 1 : 1;
            for (int j = 1; j <= post; j++) begin
                tick();
                set_idle();
                hold = tk && (j <= d);
                if (j < post) id_valid = 1'($urandom_range(0, 1));
                if_ready = tk && (j == d);
                @(negedge clk);
                checks++; if (bus.redirect_valid !== hold || bus.stall !== (hold && id_valid)) begin failures++; $display("FAIL rnd%0d_post%0d: got rv=%b stall=%b want %b/%b", e, j, bus.redirect_valid, bus.stall, hold, hold && id_valid); end
                if (hold) begin
                    checks++; if (bus.redirect_pc !== tgt) begin failures++; $display("FAIL rnd%0d_hold_pc: got %h want %h", e, bus.redirect_pc, tgt); end
                end
                checks++; if (bus.ds_branch_err !== (ds_br && j == 1)) begin failures++; $display("FAIL rnd%0d_err%0d: got %b want %b", e, j, bus.ds_branch_err, ds_br && j == 1); end
            end
            checks++; if (br_total !== sat16(m_total) || br_taken !== sat16(m_taken) || s_total !== sat2(m_total) || s_taken !== sat2(m_taken)) begin
                failures++;
                $display("FAIL rnd%0d_cnt: got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d", e, br_total, br_taken, s_total, s_taken, sat16(m_total), sat16(m_taken), sat2(m_total), sat2(m_taken));
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_total  = 0;
        m_taken  = 0;
        rst_n    = 1'b0;
        set_idle();
        test_reset();
        test_taken_beq();
        test_not_taken_bne();
        test_hazard();
        test_offsets();
        test_delay_slot_branch();
        test_reset_abort();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
